// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word reads and queues {pc, instr} for decode.
// Optional IFETCH_PERF_EN adds saturating bubble/flush counters.
module ifetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             dec_valid,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      perf_bubble_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam int unsigned      AW         = $clog2(DEPTH);
  localparam int unsigned      CW         = AW + 1;
  localparam logic [CW:0]      CREDITS    = DEPTH[CW:0];
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [WIDTH-1:0] q_pc    [DEPTH];
  logic [WIDTH-1:0] q_instr [DEPTH];
  logic [WIDTH-1:0] tag_pc  [DEPTH];

  logic [CW:0] in_use;
  logic        req_fire, rsp_fire, enq, deq;

  // Every accepted request holds a queue slot until its response is consumed or dropped.
  assign in_use         = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !reset && !redirect && (in_use < CREDITS);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outst_q != '0);
  assign dec_valid      = (count_q != '0);
  assign deq            = dec_valid && dec_ready && !redirect;
  assign enq            = rsp_fire && (state_q == RUN) && !redirect;

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign dec_instr     = dec_valid ? q_instr[rd_ptr_q] : '0;
  assign dec_pc        = dec_valid ? q_pc[rd_ptr_q]    : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;

    if (rsp_fire) begin
      outst_d  = outst_d - CW'(1);
      tag_rd_d = tag_rd_q + AW'(1);
    end
    if (req_fire) begin
      outst_d  = outst_d + CW'(1);
      tag_wr_d = tag_wr_q + AW'(1);
      pc_d     = pc_q + PC_STEP;
    end

    if (redirect) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      pc_d     = redirect_pc & ALIGN_MASK;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = outst_d;
      state_d  = (outst_d != '0) ? DRAIN : RUN;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
      if (state_q == DRAIN && rsp_fire) begin
        drop_d = drop_q - CW'(1);
        if (drop_q == CW'(1)) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_pc[tag_wr_q] <= pc_q;
    if (enq) begin
      q_pc[wr_ptr_q]    <= tag_pc[tag_rd_q];
      q_instr[wr_ptr_q] <= imem_rsp_data;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (!dec_valid && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect && perf_flush_cnt != '1)    perf_flush_cnt  <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
